// File: rtl/neur_update_ctrl.sv
// Neuron SRAM read-modify-write sequencer: arbitrates SPI writes, synaptic events
// and time-reference leak sweeps onto a single-port memory as 2-cycle RD/WR pairs.
module neur_update_ctrl #(
  parameter int N = 256,
  parameter int M = 8
) (
  input  logic         CLK,
  input  logic         RSTN_syncn,
  input  logic         SPI_GATE_ACTIVITY_sync,
  input  logic         SPI_REQ,
  input  logic [M-1:0] SPI_ADDR,
  output logic         SPI_ACK,
  input  logic         EVT_REQ,
  input  logic [M-1:0] EVT_ADDR,
  output logic         EVT_ACK,
  input  logic         TREF_REQ,
  output logic         TREF_ACK,
  output logic         CTRL_NEURMEM_CS,
  output logic         CTRL_NEURMEM_WE,
  output logic [M-1:0] CTRL_NEURMEM_ADDR,
  output logic         CTRL_NEUR_EVENT,
  output logic         CTRL_NEUR_TREF,
  output logic         BUSY
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  typedef enum logic [1:0] {SRC_SPI, SRC_EVT, SRC_SWEEP} src_t;

  localparam logic [M-1:0] LAST = M'(N - 1);

  state_t       state;
  src_t         src;
  logic [M-1:0] target;
  logic [M-1:0] sweep_cnt;
  logic         sweep_act;

  logic         in_wr;
  logic         sweep_wr;
  logic         sweep_done;
  logic         spi_ok;
  logic         evt_ok;
  logic         new_tref;
  logic         sweep_cont;
  logic [M-1:0] sweep_cnt_next;

  logic         grant;
  src_t         grant_src;
  logic [M-1:0] grant_addr;

  // The source acked in the current WR is masked so its stale REQ level is never re-served.
  assign in_wr          = (state == WR);
  assign sweep_wr       = in_wr && (src == SRC_SWEEP);
  assign sweep_done     = sweep_wr && (sweep_cnt == LAST);
  assign spi_ok         = SPI_REQ && !(in_wr && (src == SRC_SPI));
  assign evt_ok         = EVT_REQ && !(in_wr && (src == SRC_EVT));
  assign new_tref       = TREF_REQ && !sweep_act && !sweep_wr;
  assign sweep_cont     = sweep_act && !sweep_done;
  assign sweep_cnt_next = sweep_wr ? sweep_cnt + 1'b1 : sweep_cnt;

  always_comb begin
    grant      = 1'b0;
    grant_src  = SRC_SPI;
    grant_addr = '0;
    if (SPI_GATE_ACTIVITY_sync) begin
      if (spi_ok) begin
        grant      = 1'b1;
        grant_src  = SRC_SPI;
        grant_addr = SPI_ADDR;
      end
    end else if (evt_ok) begin
      grant      = 1'b1;
      grant_src  = SRC_EVT;
      grant_addr = EVT_ADDR;
    end else if (sweep_cont || new_tref) begin
      grant      = 1'b1;
      grant_src  = SRC_SWEEP;
      grant_addr = new_tref ? '0 : sweep_cnt_next;
    end
  end

  always_ff @(posedge CLK or negedge RSTN_syncn) begin
    if (!RSTN_syncn) begin
      state             <= IDLE;
      src               <= SRC_SPI;
      target            <= '0;
      sweep_cnt         <= '0;
      sweep_act         <= 1'b0;
      CTRL_NEURMEM_CS   <= 1'b0;
      CTRL_NEURMEM_WE   <= 1'b0;
      CTRL_NEURMEM_ADDR <= '0;
      CTRL_NEUR_EVENT   <= 1'b0;
      CTRL_NEUR_TREF    <= 1'b0;
      SPI_ACK           <= 1'b0;
      EVT_ACK           <= 1'b0;
      TREF_ACK          <= 1'b0;
    end else begin
      if (sweep_wr) begin
        sweep_cnt <= sweep_cnt_next;
        if (sweep_done) sweep_act <= 1'b0;
      end
      case (state)
        IDLE, WR: begin
          CTRL_NEUR_EVENT <= 1'b0;
          CTRL_NEUR_TREF  <= 1'b0;
          SPI_ACK         <= 1'b0;
          EVT_ACK         <= 1'b0;
          TREF_ACK        <= 1'b0;
          CTRL_NEURMEM_WE <= 1'b0;
          if (grant) begin
            state             <= RD;
            src               <= grant_src;
            target            <= grant_addr;
            CTRL_NEURMEM_CS   <= 1'b1;
            CTRL_NEURMEM_ADDR <= grant_addr;
            // A fresh sweep starts on the same edge as its first neuron grant.
            if ((grant_src == SRC_SWEEP) && new_tref) begin
              sweep_act <= 1'b1;
              sweep_cnt <= '0;
            end
          end else begin
            state             <= IDLE;
            CTRL_NEURMEM_CS   <= 1'b0;
            CTRL_NEURMEM_ADDR <= '0;
          end
        end
        RD: begin
          state           <= WR;
          CTRL_NEURMEM_WE <= 1'b1;
          CTRL_NEUR_EVENT <= (src == SRC_EVT);
          CTRL_NEUR_TREF  <= (src == SRC_SWEEP);
          SPI_ACK         <= (src == SRC_SPI);
          EVT_ACK         <= (src == SRC_EVT);
          TREF_ACK        <= (src == SRC_SWEEP) && (target == LAST);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE) || sweep_act;

endmodule

// File: tb/tb_neur_update_ctrl.sv
// Scoreboard bench for neur_update_ctrl: expected WR transactions are queued as
// stimulus is driven and compared as each SRAM write appears on the outputs.
module tb_neur_update_ctrl;

  localparam int N = 256;
  localparam int M = 8;

  logic         CLK = 1'b0;
  logic         RSTN_syncn;
  logic         SPI_GATE_ACTIVITY_sync;
  logic         SPI_REQ;
  logic [M-1:0] SPI_ADDR;
  logic         SPI_ACK;
  logic         EVT_REQ;
  logic [M-1:0] EVT_ADDR;
  logic         EVT_ACK;
  logic         TREF_REQ;
  logic         TREF_ACK;
  logic         CTRL_NEURMEM_CS;
  logic         CTRL_NEURMEM_WE;
  logic [M-1:0] CTRL_NEURMEM_ADDR;
  logic         CTRL_NEUR_EVENT;
  logic         CTRL_NEUR_TREF;
  logic         BUSY;

  neur_update_ctrl #(.N(N), .M(M)) dut (
    .CLK                    (CLK),
    .RSTN_syncn             (RSTN_syncn),
    .SPI_GATE_ACTIVITY_sync (SPI_GATE_ACTIVITY_sync),
    .SPI_REQ                (SPI_REQ),
    .SPI_ADDR               (SPI_ADDR),
    .SPI_ACK                (SPI_ACK),
    .EVT_REQ                (EVT_REQ),
    .EVT_ADDR               (EVT_ADDR),
    .EVT_ACK                (EVT_ACK),
    .TREF_REQ               (TREF_REQ),
    .TREF_ACK               (TREF_ACK),
    .CTRL_NEURMEM_CS        (CTRL_NEURMEM_CS),
    .CTRL_NEURMEM_WE        (CTRL_NEURMEM_WE),
    .CTRL_NEURMEM_ADDR      (CTRL_NEURMEM_ADDR),
    .CTRL_NEUR_EVENT        (CTRL_NEUR_EVENT),
    .CTRL_NEUR_TREF         (CTRL_NEUR_TREF),
    .BUSY                   (BUSY)
  );

  always #5 CLK = ~CLK;

  // Flag order: {EVENT, TREF, SPI_ACK, EVT_ACK, TREF_ACK}
  typedef struct packed {
    logic [7:0] addr;
    logic [4:0] flags;
  } exp_t;

  localparam logic [4:0] F_SPI       = 5'b00100;
  localparam logic [4:0] F_EVT       = 5'b10010;
  localparam logic [4:0] F_TREF      = 5'b01000;
  localparam logic [4:0] F_TREF_LAST = 5'b01001;

  exp_t       sb_q[$];
  int         num_checks = 0;
  int         num_errors = 0;
  int         cyc = 0;
  logic       have_rd = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [4:0] obs_flags;
  int         req_cyc, ack_cyc, evt_cyc, spi_cyc, sw_cyc;

  assign obs_flags = {CTRL_NEUR_EVENT, CTRL_NEUR_TREF, SPI_ACK, EVT_ACK, TREF_ACK};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic gate, input logic spi_req, input logic [7:0] spi_addr,
                               input logic evt_req, input logic [7:0] evt_addr, input logic tref_req);
    SPI_GATE_ACTIVITY_sync = gate;
    SPI_REQ                = spi_req;
    SPI_ADDR               = spi_addr;
    EVT_REQ                = evt_req;
    EVT_ADDR               = evt_addr;
    TREF_REQ               = tref_req;
  endtask

  task automatic pushExp(input logic [7:0] addr, input logic [4:0] flags);
    exp_t e;
    e.addr  = addr;
    e.flags = flags;
    sb_q.push_back(e);
  endtask

  task automatic pushSweep(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      pushExp(8'(i), (i == N - 1) ? F_TREF_LAST : F_TREF);
  endtask

  // sel: 0 = SPI_ACK, 1 = EVT_ACK, 2 = TREF_ACK
  task automatic waitAck(input int sel, input int limit, input string tag, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      if ((sel == 0 && SPI_ACK) || (sel == 1 && EVT_ACK) || (sel == 2 && TREF_ACK)) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic waitAccess(input logic [7:0] addr, input logic we, input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      if (CTRL_NEURMEM_CS && CTRL_NEURMEM_WE == we && CTRL_NEURMEM_ADDR == addr) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic checkIdle(input string tag);
    repeat (4) @(negedge CLK);
    checkOutput({tag, "_sb_empty"}, sb_q.size(), 0);
    checkOutput({tag, "_busy"}, BUSY, 0);
  endtask

  // Monitor: every RD/WR pair is checked for shape; each WR is matched against the scoreboard.
  always @(negedge CLK) begin
    if (!RSTN_syncn) begin
      have_rd = 1'b0;
    end else if (!CTRL_NEURMEM_CS) begin
      checkOutput("idle_outs", {CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, obs_flags}, 0);
      have_rd = 1'b0;
    end else if (!CTRL_NEURMEM_WE) begin
      checkOutput("rd_strobes", obs_flags, 0);
      rd_addr = CTRL_NEURMEM_ADDR;
      have_rd = 1'b1;
    end else begin
      checkOutput("rd_before_wr", have_rd, 1);
      if (have_rd) checkOutput("wr_addr_vs_rd", CTRL_NEURMEM_ADDR, rd_addr);
      have_rd = 1'b0;
      if (sb_q.size() == 0) begin
        checkOutput("wr_without_expect", {23'd0, 1'b1, CTRL_NEURMEM_ADDR}, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("wr_addr", CTRL_NEURMEM_ADDR, e.addr);
        checkOutput("wr_flags", obs_flags, e.flags);
      end
    end
  end

  initial begin
    RSTN_syncn = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("reset_outs", {CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT,
                               CTRL_NEUR_TREF, SPI_ACK, EVT_ACK, TREF_ACK, BUSY}, 0);
    @(negedge CLK);
    RSTN_syncn = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] single event");
    pushExp(8'h2A, F_EVT);
    @(posedge CLK); #1;
    EVT_ADDR = 8'h2A; EVT_REQ = 1'b1; req_cyc = cyc;
    waitAck(1, 20, "t1_evt", ack_cyc);
    @(posedge CLK); #1 EVT_REQ = 1'b0;
    checkOutput("t1_latency", ack_cyc - req_cyc, 2);
    checkIdle("t1");

    $display("[TB] full sweep");
    pushSweep(0, N - 1);
    @(posedge CLK); #1;
    TREF_REQ = 1'b1; req_cyc = cyc;
    waitAck(2, 3000, "t2_tref", ack_cyc);
    @(posedge CLK); #1 TREF_REQ = 1'b0;
    checkOutput("t2_latency", ack_cyc - req_cyc, 2 * N);
    checkIdle("t2");

    $display("[TB] event preempts sweep");
    pushSweep(0, 5);
    pushExp(8'h10, F_EVT);
    pushSweep(6, N - 1);
    @(posedge CLK); #1 TREF_REQ = 1'b1;
    fork
      begin
        waitAck(2, 3000, "t3_tref", sw_cyc);
        @(posedge CLK); #1 TREF_REQ = 1'b0;
      end
      begin
        waitAccess(8'd5, 1'b0, 100, "t3_rd5");
        EVT_ADDR = 8'h10; EVT_REQ = 1'b1;
        waitAck(1, 20, "t3_evt", evt_cyc);
        @(posedge CLK); #1 EVT_REQ = 1'b0;
      end
    join
    checkIdle("t3");

    $display("[TB] gate during sweep");
    pushSweep(0, 100);
    pushExp(8'h80, F_SPI);
    pushExp(8'h33, F_EVT);
    pushSweep(101, N - 1);
    @(posedge CLK); #1 TREF_REQ = 1'b1;
    fork
      begin
        waitAck(2, 3000, "t4_tref", sw_cyc);
        @(posedge CLK); #1 TREF_REQ = 1'b0;
      end
      begin
        waitAccess(8'd100, 1'b0, 400, "t4_rd100");
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b1, 8'h33, 1'b1);
        waitAck(0, 20, "t4_spi", spi_cyc);
        @(posedge CLK); #1 SPI_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("t4_gate_cs", CTRL_NEURMEM_CS, 0);
        checkOutput("t4_gate_busy", BUSY, 1);
        @(posedge CLK); #1 SPI_GATE_ACTIVITY_sync = 1'b0;
        waitAck(1, 20, "t4_evt", evt_cyc);
        @(posedge CLK); #1 EVT_REQ = 1'b0;
      end
    join
    checkIdle("t4");

    $display("[TB] SPI ignored with gate low, then ack masking");
    @(posedge CLK); #1;
    SPI_ADDR = 8'h44; SPI_REQ = 1'b1;
    repeat (6) @(negedge CLK);
    checkOutput("t5_spi_ignored_cs", CTRL_NEURMEM_CS, 0);
    @(posedge CLK); #1 SPI_REQ = 1'b0;
    pushExp(8'h11, F_EVT);
    pushExp(8'h22, F_EVT);
    EVT_ADDR = 8'h11; EVT_REQ = 1'b1;
    waitAck(1, 20, "t5_evt_a", ack_cyc);
    @(posedge CLK); #1 EVT_ADDR = 8'h22;
    waitAck(1, 20, "t5_evt_b", evt_cyc);
    @(posedge CLK); #1 EVT_REQ = 1'b0;
    checkOutput("t5_second_ack_soon", (evt_cyc > ack_cyc) && (evt_cyc - ack_cyc <= 3), 1);
    checkIdle("t5");

    $display("[TB] async reset mid-sweep");
    pushSweep(0, 37);
    @(posedge CLK); #1 TREF_REQ = 1'b1;
    waitAccess(8'd37, 1'b1, 200, "t6_wr37");
    #2;
    RSTN_syncn = 1'b0;
    TREF_REQ   = 1'b0;
    #1;
    checkOutput("t6_reset_outs", {CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT,
                                  CTRL_NEUR_TREF, SPI_ACK, EVT_ACK, TREF_ACK, BUSY}, 0);
    @(negedge CLK);
    RSTN_syncn = 1'b1;
    checkIdle("t6_abandon");
    pushSweep(0, N - 1);
    @(posedge CLK); #1;
    TREF_REQ = 1'b1; req_cyc = cyc;
    waitAck(2, 3000, "t6_tref", ack_cyc);
    @(posedge CLK); #1 TREF_REQ = 1'b0;
    checkOutput("t6_latency", ack_cyc - req_cyc, 2 * N);
    checkIdle("t6");

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
